// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. a one-entry buffered
// out-of-order multicycle result, plus a pending-destination scoreboard for decode hazards.
module regfile_wb_arbiter #(
   parameter int WIDTH        = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             pipe_wr_en,
   input  logic [4:0]       pipe_wr_addr,
   input  logic [WIDTH-1:0] pipe_wr_data,

   input  logic             mc_valid,
   input  logic [4:0]       mc_addr,
   input  logic [WIDTH-1:0] mc_data,
   output logic             mc_ready,

   input  logic             mc_issue,
   input  logic [4:0]       mc_issue_addr,

   input  logic [4:0]       dec_rs,
   input  logic [4:0]       dec_rt,
   input  logic [4:0]       dec_dst,
   input  logic             dec_dst_valid,
   output logic             stall,

   output logic             wb_hold,

   output logic             regwrite,
   output logic [4:0]       address_wb,
   output logic [WIDTH-1:0] data_wb
);

   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
   localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

   logic             buf_valid_q, buf_valid_d;
   logic [4:0]       buf_addr_q,  buf_addr_d;
   logic [WIDTH-1:0] buf_data_q,  buf_data_d;
   logic [31:0]      pending_q,   pending_d;
   logic [3:0]       cnt_q,       cnt_d;
   logic             wb_hold_q,   wb_hold_d;

   logic pipe_use;
   logic drain;
   logic blocked;
   logic accept;

   // A pipeline write to r0 is discarded, so it never takes the port from the buffer.
   assign pipe_use = pipe_wr_en && (pipe_wr_addr != 5'd0);
   assign drain    = buf_valid_q && !pipe_use;
   assign blocked  = buf_valid_q && !drain;
   assign mc_ready = !rst && (!buf_valid_q || drain);
   assign accept   = mc_valid && mc_ready;
   assign wb_hold  = wb_hold_q;

   always_comb begin
      regwrite   = 1'b0;
      address_wb = 5'd0;
      data_wb    = '0;
      if (!rst) begin
         if (pipe_use) begin
            regwrite   = 1'b1;
            address_wb = pipe_wr_addr;
            data_wb    = pipe_wr_data;
         end else if (drain) begin
            regwrite   = 1'b1;
            address_wb = buf_addr_q;
            data_wb    = buf_data_q;
         end
      end
   end

   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         stall = ((dec_rs != 5'd0) && pending_q[dec_rs])
              || ((dec_rt != 5'd0) && pending_q[dec_rt])
              || (dec_dst_valid && (dec_dst != 5'd0) && pending_q[dec_dst]);
      end
   end

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_addr_d  = buf_addr_q;
      buf_data_d  = buf_data_q;
      if (accept) begin
         // An r0 result is acknowledged but never occupies the buffer.
         buf_valid_d = (mc_addr != 5'd0);
         buf_addr_d  = mc_addr;
         buf_data_d  = mc_data;
      end else if (drain) begin
         buf_valid_d = 1'b0;
      end
   end

   // Clear before set so a same-cycle issue to the draining register stays pending.
   always_comb begin
      pending_d = pending_q;
      if (drain) begin
         pending_d[buf_addr_q] = 1'b0;
      end
      if (mc_issue && (mc_issue_addr != 5'd0)) begin
         pending_d[mc_issue_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d     = cnt_q;
      wb_hold_d = wb_hold_q;
      if (!blocked) begin
         cnt_d = 4'd0;
      end else if (cnt_q < LIMIT) begin
         cnt_d = cnt_q + 4'd1;
      end
      if (blocked && (cnt_q == LIMIT_M1)) begin
         wb_hold_d = 1'b1;
      end else if (drain) begin
         wb_hold_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
         buf_addr_q  <= 5'd0;
         buf_data_q  <= '0;
         pending_q   <= 32'd0;
         cnt_q       <= 4'd0;
         wb_hold_q   <= 1'b0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_addr_q  <= buf_addr_d;
         buf_data_q  <= buf_data_d;
         pending_q   <= pending_d;
         cnt_q       <= cnt_d;
         wb_hold_q   <= wb_hold_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected values are hand-computed per vector.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_wr_en;
   logic [4:0]  pipe_wr_addr;
   logic [31:0] pipe_wr_data;
   logic        mc_valid;
   logic [4:0]  mc_addr;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        mc_issue;
   logic [4:0]  mc_issue_addr;
   logic [4:0]  dec_rs, dec_rt, dec_dst;
   logic        dec_dst_valid;
   logic        stall;
   logic        wb_hold;
   logic        regwrite;
   logic [4:0]  address_wb;
   logic [31:0] data_wb;

   int vectors = 0;
   int miscompares = 0;

   regfile_wb_arbiter #(.WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_wr_en    (pipe_wr_en),
      .pipe_wr_addr  (pipe_wr_addr),
      .pipe_wr_data  (pipe_wr_data),
      .mc_valid      (mc_valid),
      .mc_addr       (mc_addr),
      .mc_data       (mc_data),
      .mc_ready      (mc_ready),
      .mc_issue      (mc_issue),
      .mc_issue_addr (mc_issue_addr),
      .dec_rs        (dec_rs),
      .dec_rt        (dec_rt),
      .dec_dst       (dec_dst),
      .dec_dst_valid (dec_dst_valid),
      .stall         (stall),
      .wb_hold       (wb_hold),
      .regwrite      (regwrite),
      .address_wb    (address_wb),
      .data_wb       (data_wb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past the next posedge; inputs are then changed and outputs sampled mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b1;
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'h1234_5678;
      mc_valid = 1'b1;   mc_addr = 5'd7;      mc_data = 32'h8765_4321;
      mc_issue = 1'b0;   mc_issue_addr = 5'd0;
      dec_rs = 5'd0; dec_rt = 5'd0; dec_dst = 5'd0; dec_dst_valid = 1'b0;

      // Reset
      tick(); settle();
      check("rst_regwrite", 32'(regwrite), 32'd0);
      check("rst_mc_ready", 32'(mc_ready), 32'd0);
      check("rst_stall",    32'(stall),    32'd0);
      tick();
      rst = 1'b0; pipe_wr_en = 1'b0; mc_valid = 1'b0;
      settle();
      check("rel_mc_ready", 32'(mc_ready), 32'd1);
      check("rel_regwrite", 32'(regwrite), 32'd0);
      check("rel_wb_hold",  32'(wb_hold),  32'd0);
      for (int r = 1; r < 32; r += 10) begin
         dec_rs = 5'(r); #1;
         check("rel_pending", 32'(stall), 32'd0);
      end
      dec_rs = 5'd0;

      // Pipeline priority over multicycle
      tick();
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd5; pipe_wr_data = 32'hAAAA_0001;
      mc_valid = 1'b1;   mc_addr = 5'd7;      mc_data = 32'hBBBB_0002;
      settle();
      check("pri_regwrite", 32'(regwrite),   32'd1);
      check("pri_addr",     32'(address_wb), 32'd5);
      check("pri_data",     data_wb,         32'hAAAA_0001);
      check("pri_mc_ready", 32'(mc_ready),   32'd1);
      tick();
      pipe_wr_en = 1'b0; mc_valid = 1'b0;
      settle();
      check("drn_regwrite", 32'(regwrite),   32'd1);
      check("drn_addr",     32'(address_wb), 32'd7);
      check("drn_data",     data_wb,         32'hBBBB_0002);
      tick(); settle();
      check("idle_regwrite", 32'(regwrite),   32'd0);
      check("idle_addr",     32'(address_wb), 32'd0);

      // Scoreboard RAW/WAW
      mc_issue = 1'b1; mc_issue_addr = 5'd9; dec_rs = 5'd9;
      settle();
      check("sb_issue_cycle", 32'(stall), 32'd0);
      tick();
      mc_issue = 1'b0;
      settle();
      check("sb_rs_stall", 32'(stall), 32'd1);
      dec_rs = 5'd0; dec_dst = 5'd9; dec_dst_valid = 1'b1; #1;
      check("sb_dst_stall", 32'(stall), 32'd1);
      dec_dst_valid = 1'b0; #1;
      check("sb_dst_invalid", 32'(stall), 32'd0);
      check("sb_rs0", 32'(stall), 32'd0);
      dec_rs = 5'd9;
      mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h0000_0099;
      #1;
      check("sb_accept_stall", 32'(stall),    32'd1);
      check("sb_accept_rdy",   32'(mc_ready), 32'd1);
      tick();
      mc_valid = 1'b0;
      settle();
      check("sb_drain_stall", 32'(stall),      32'd1);
      check("sb_drain_addr",  32'(address_wb), 32'd9);
      check("sb_drain_data",  data_wb,         32'h0000_0099);
      tick(); settle();
      check("sb_after_drain", 32'(stall), 32'd0);
      dec_rs = 5'd0;

      // Starvation and wb_hold
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd1; pipe_wr_data = 32'h0000_0011;
      mc_valid = 1'b1;   mc_addr = 5'd3;      mc_data = 32'h0000_0033;
      settle();
      check("stv_load_rdy", 32'(mc_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         mc_valid = 1'b0;
         pipe_wr_addr = 5'(i + 1); pipe_wr_data = 32'(i);
         settle();
         check("stv_blk_rdy",  32'(mc_ready),   32'd0);
         check("stv_blk_hold", 32'(wb_hold),    32'd0);
         check("stv_blk_addr", 32'(address_wb), 32'(i + 1));
      end
      tick();
      pipe_wr_addr = 5'd2; pipe_wr_data = 32'h0000_0022;
      settle();
      check("stv_hold_set",  32'(wb_hold),    32'd1);
      check("stv_viol_addr", 32'(address_wb), 32'd2);
      tick(); settle();
      check("stv_viol_hold", 32'(wb_hold), 32'd1);
      pipe_wr_en = 1'b0; #1;
      check("stv_drain_addr", 32'(address_wb), 32'd3);
      check("stv_drain_data", data_wb,         32'h0000_0033);
      check("stv_drain_rdy",  32'(mc_ready),   32'd1);
      check("stv_drain_hold", 32'(wb_hold),    32'd1);
      tick(); settle();
      check("stv_hold_clr", 32'(wb_hold),  32'd0);
      check("stv_idle_wr",  32'(regwrite), 32'd0);

      // r0 handling
      mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 32'h0000_0066;
      tick();
      mc_valid = 1'b0;
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'h0000_DEAD;
      settle();
      check("r0_pipe_wr",   32'(regwrite),   32'd1);
      check("r0_pipe_addr", 32'(address_wb), 32'd6);
      check("r0_pipe_data", data_wb,         32'h0000_0066);
      tick();
      pipe_wr_en = 1'b0;
      mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h0000_0077;
      settle();
      check("r0_mc_rdy", 32'(mc_ready), 32'd1);
      check("r0_mc_wr",  32'(regwrite), 32'd0);
      tick();
      mc_valid = 1'b0;
      settle();
      check("r0_mc_nowr",  32'(regwrite), 32'd0);
      check("r0_mc_ready", 32'(mc_ready), 32'd1);

      // Same-cycle set/clear of r4
      mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'h0000_0044;
      tick();
      mc_valid = 1'b0;
      mc_issue = 1'b1; mc_issue_addr = 5'd4;
      settle();
      check("race_drain_addr", 32'(address_wb), 32'd4);
      tick();
      mc_issue = 1'b0; dec_rt = 5'd4;
      settle();
      check("race_rt_stall", 32'(stall), 32'd1);

      // Reset with a blocked buffered write discards it
      pipe_wr_en = 1'b1; pipe_wr_addr = 5'd2; pipe_wr_data = 32'h0000_0002;
      mc_valid = 1'b1;   mc_addr = 5'd8;      mc_data = 32'h0000_0088;
      tick();
      mc_valid = 1'b0; pipe_wr_en = 1'b0; rst = 1'b1;
      settle();
      check("mid_rst_wr",    32'(regwrite), 32'd0);
      check("mid_rst_rdy",   32'(mc_ready), 32'd0);
      check("mid_rst_stall", 32'(stall),    32'd0);
      tick();
      rst = 1'b0;
      settle();
      check("post_rst_wr",    32'(regwrite), 32'd0);
      check("post_rst_stall", 32'(stall),    32'd0);
      tick(); settle();
      check("post_rst_idle",  32'(regwrite), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
